sp_tracker_pno: RTL and testbench

//  N-axis perturb-and-observe solar-panel tracker: hill-climbs each servo axis on sampled panel voltage.

---
 rtl/sp_tracker_pno.sv | 226 ++++++++++++++++++++++
 tb/tb_sp_tracker_pno.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_tracker_pno.sv
// sp_tracker_pno: N-axis perturb-and-observe solar tracker with manual jog mode and servo PWM.
// One axis is perturbed at a time; two non-improving decisions hand the search to the next axis.
module sp_tracker_pno #(
   parameter int NAXES      = 2,
   parameter int VW         = 12,
   parameter int POS_W      = 8,
   parameter int STEP       = 4,
   parameter int HYST       = 8,
   parameter int SETTLE_CYC = 1000000,
   parameter int PWM_PERIOD = 2000000,
   parameter int PWM_MIN    = 100000,
   parameter int PWM_K      = 392
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   BTN_C,
   input  logic [NAXES-1:0]       BTN_INC,
   input  logic [NAXES-1:0]       BTN_DEC,
   input  logic [VW-1:0]          V_in,
   input  logic                   V_valid,
   output logic [NAXES-1:0]       SERVO,
   output logic [NAXES*POS_W-1:0] POS,
   output logic [NAXES-1:0]       DIR,
   output logic [VW-1:0]          MAX_V,
   output logic [2:0]             STAT
);

   typedef enum logic [2:0] {
      S_MANUAL = 3'd0,
      S_INIT   = 3'd1,
      S_MOVE   = 3'd2,
      S_SETTLE = 3'd3,
      S_SAMPLE = 3'd4,
      S_DECIDE = 3'd5
   } state_t;

   localparam int               AX_W    = (NAXES > 1) ? $clog2(NAXES) : 1;
   localparam int               NB      = 2 * NAXES + 1;
   localparam logic [POS_W-1:0] POS_MAX = '1;
   localparam logic [POS_W-1:0] POS_MID = {1'b1, {(POS_W-1){1'b0}}};
   localparam logic [POS_W:0]   STEP_E  = (POS_W+1)'(STEP);
   localparam logic [VW:0]      HYST_E  = (VW+1)'(HYST);

   // Saturating moves; the MSB of the result flags that the step was clamped.
   function automatic logic [POS_W:0] step_up(input logic [POS_W-1:0] p);
      logic [POS_W:0] s;
      s = {1'b0, p} + STEP_E;
      if (s > {1'b0, POS_MAX}) return {1'b1, POS_MAX};
      return {1'b0, s[POS_W-1:0]};
   endfunction

   function automatic logic [POS_W:0] step_dn(input logic [POS_W-1:0] p);
      if ({1'b0, p} < STEP_E) return {1'b1, {POS_W{1'b0}}};
      return {1'b0, p - STEP_E[POS_W-1:0]};
   endfunction

   logic [NB-1:0]    btn_s1_q, btn_s2_q, btn_prev_q, btn_edge;
   logic             btn_c_edge;
   logic [NAXES-1:0] inc_edge, dec_edge;

   assign btn_edge   = btn_s2_q & ~btn_prev_q;
   assign btn_c_edge = btn_edge[0];
   assign inc_edge   = btn_edge[NAXES:1];
   assign dec_edge   = btn_edge[2*NAXES:NAXES+1];

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         btn_s1_q   <= '0;
         btn_s2_q   <= '0;
         btn_prev_q <= '0;
      end else begin
         btn_s1_q   <= {BTN_DEC, BTN_INC, BTN_C};
         btn_s2_q   <= btn_s1_q;
         btn_prev_q <= btn_s2_q;
      end
   end

   state_t            state_q, state_d;
   logic [POS_W-1:0]  pos_q [NAXES];
   logic [POS_W-1:0]  pos_d [NAXES];
   logic [NAXES-1:0]  dir_q, dir_d;
   logic [AX_W-1:0]   ax_q, ax_d;
   logic [VW-1:0]     ref_q, ref_d, v_q, v_d, maxv_q;
   logic [1:0]        fail_q, fail_d;
   logic [31:0]       settle_q, settle_d;
   logic [POS_W:0]    mv;
   logic              better, worse;

   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      dir_d    = dir_q;
      ax_d     = ax_q;
      ref_d    = ref_q;
      v_d      = v_q;
      fail_d   = fail_q;
      settle_d = settle_q;
      mv       = '0;
      better   = 1'b0;
      worse    = 1'b0;
      if (state_q != S_MANUAL && btn_c_edge) begin
         state_d  = S_MANUAL;
         settle_d = '0;
      end else begin
         case (state_q)
            S_MANUAL: begin
               for (int i = 0; i < NAXES; i++) begin
                  if (inc_edge[i] && !dec_edge[i]) begin
                     mv       = step_up(pos_q[i]);
                     pos_d[i] = mv[POS_W-1:0];
                  end else if (dec_edge[i] && !inc_edge[i]) begin
                     mv       = step_dn(pos_q[i]);
                     pos_d[i] = mv[POS_W-1:0];
                  end
               end
               if (btn_c_edge) state_d = S_INIT;
            end
            S_INIT: begin
               if (V_valid) begin
                  ref_d   = V_in;
                  fail_d  = '0;
                  state_d = S_MOVE;
               end
            end
            S_MOVE: begin
               mv          = dir_q[ax_q] ? step_up(pos_q[ax_q]) : step_dn(pos_q[ax_q]);
               pos_d[ax_q] = mv[POS_W-1:0];
               if (mv[POS_W]) dir_d[ax_q] = ~dir_q[ax_q];
               settle_d    = '0;
               state_d     = S_SETTLE;
            end
            S_SETTLE: begin
               if (settle_q == 32'(SETTLE_CYC - 1)) state_d = S_SAMPLE;
               else settle_d = settle_q + 32'd1;
            end
            S_SAMPLE: begin
               if (V_valid) begin
                  v_d     = V_in;
                  state_d = S_DECIDE;
               end
            end
            S_DECIDE: begin
               // One extra bit keeps ref+HYST and v+HYST from wrapping.
               better = {1'b0, v_q} > ({1'b0, ref_q} + HYST_E);
               worse  = ({1'b0, v_q} + HYST_E) < {1'b0, ref_q};
               if (better) begin
                  ref_d  = v_q;
                  fail_d = '0;
               end else begin
                  if (worse) dir_d[ax_q] = ~dir_q[ax_q];
                  if (fail_q == 2'd1) begin
                     fail_d = '0;
                     ax_d   = (ax_q == AX_W'(NAXES - 1)) ? '0 : ax_q + 1'b1;
                     ref_d  = v_q;
                  end else begin
                     fail_d = fail_q + 2'd1;
                  end
               end
               state_d = S_MOVE;
            end
            default: state_d = S_MANUAL;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= S_MANUAL;
         for (int i = 0; i < NAXES; i++) pos_q[i] <= POS_MID;
         dir_q    <= '1;
         ax_q     <= '0;
         ref_q    <= '0;
         v_q      <= '0;
         fail_q   <= '0;
         settle_q <= '0;
         maxv_q   <= '0;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         dir_q    <= dir_d;
         ax_q     <= ax_d;
         ref_q    <= ref_d;
         v_q      <= v_d;
         fail_q   <= fail_d;
         settle_q <= settle_d;
         if (V_valid && V_in > maxv_q) maxv_q <= V_in;
      end
   end

   // Widths are captured at the frame start so a mid-frame move cannot shorten or stretch a pulse.
   logic [31:0]      pwm_cnt_q;
   logic [31:0]      width_q   [NAXES];
   logic [31:0]      width_now [NAXES];
   logic [NAXES-1:0] servo_q;

   always_comb begin
      for (int i = 0; i < NAXES; i++)
         width_now[i] = (pwm_cnt_q == 32'd0) ? (32'(PWM_MIN) + 32'(pos_q[i]) * 32'(PWM_K))
                                             : width_q[i];
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pwm_cnt_q <= '0;
         for (int i = 0; i < NAXES; i++) width_q[i] <= '0;
         servo_q   <= '0;
      end else begin
         pwm_cnt_q <= (pwm_cnt_q == 32'(PWM_PERIOD - 1)) ? 32'd0 : pwm_cnt_q + 32'd1;
         for (int i = 0; i < NAXES; i++) begin
            width_q[i] <= width_now[i];
            servo_q[i] <= (pwm_cnt_q < width_now[i]);
         end
      end
   end

   always_comb begin
      POS = '0;
      for (int i = 0; i < NAXES; i++) POS[i*POS_W +: POS_W] = pos_q[i];
   end

   assign SERVO = servo_q;
   assign DIR   = dir_q;
   assign MAX_V = maxv_q;
   assign STAT  = state_q;

endmodule

// File: tb/tb_sp_tracker_pno.sv
// Scoreboard bench for sp_tracker_pno with shortened settle/PWM timing.
// A behavioural model predicts positions/directions; expectations are queued at stimulus time.
module tb_sp_tracker_pno;

   localparam int NAXES = 2, VW = 12, POS_W = 8, STEP = 4, HYST = 8;
   localparam int SETTLE = 4, PERIOD = 1000, PMIN = 50, PK = 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              btn_c = 1'b0;
   logic [NAXES-1:0]  btn_inc = '0, btn_dec = '0;
   logic [VW-1:0]     v_in = '0;
   logic              v_valid = 1'b0;
   logic [NAXES-1:0]  servo;
   logic [NAXES*POS_W-1:0] pos;
   logic [NAXES-1:0]  dir;
   logic [VW-1:0]     max_v;
   logic [2:0]        stat;

   sp_tracker_pno #(
      .NAXES(NAXES), .VW(VW), .POS_W(POS_W), .STEP(STEP), .HYST(HYST),
      .SETTLE_CYC(SETTLE), .PWM_PERIOD(PERIOD), .PWM_MIN(PMIN), .PWM_K(PK)
   ) dut (
      .CLK(clk), .RST_N(rst_n), .BTN_C(btn_c), .BTN_INC(btn_inc), .BTN_DEC(btn_dec),
      .V_in(v_in), .V_valid(v_valid), .SERVO(servo), .POS(pos), .DIR(dir),
      .MAX_V(max_v), .STAT(stat)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct { string tag; int exp; } exp_t;
   exp_t sb_q[$];

   int m_pos[NAXES];
   int m_dir[NAXES];
   int m_ax, m_ref, m_fail, m_max;

   task automatic chk(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic void sb_push(input string tag, input int exp);
      exp_t e;
      e.tag = tag;
      e.exp = exp;
      sb_q.push_back(e);
   endfunction

   task automatic sb_pop(input int act);
      exp_t e;
      if (sb_q.size() == 0) chk("sb_underflow", sb_q.size(), 1);
      else begin
         e = sb_q.pop_front();
         chk(e.tag, act, e.exp);
      end
   endtask

   function automatic int p0(); return int'(pos[POS_W-1:0]); endfunction
   function automatic int p1(); return int'(pos[2*POS_W-1:POS_W]); endfunction
   function automatic int m_dirv(); return m_dir[0] + 2 * m_dir[1]; endfunction

   function automatic void m_reset();
      for (int i = 0; i < NAXES; i++) begin m_pos[i] = 128; m_dir[i] = 1; end
      m_ax = 0; m_ref = 0; m_fail = 0; m_max = 0;
   endfunction

   function automatic void m_jog(input int a, input int up);
      int n;
      n = up ? m_pos[a] + STEP : m_pos[a] - STEP;
      m_pos[a] = (n > 255) ? 255 : (n < 0) ? 0 : n;
   endfunction

   function automatic void m_move();
      int n;
      n = m_dir[m_ax] ? m_pos[m_ax] + STEP : m_pos[m_ax] - STEP;
      if (n > 255) begin n = 255; m_dir[m_ax] ^= 1; end
      else if (n < 0) begin n = 0; m_dir[m_ax] ^= 1; end
      m_pos[m_ax] = n;
   endfunction

   function automatic void m_decide(input int v);
      if (v > m_ref + HYST) begin
         m_ref = v; m_fail = 0;
      end else begin
         if (v + HYST < m_ref) m_dir[m_ax] ^= 1;
         m_fail++;
         if (m_fail == 2) begin
            m_fail = 0;
            m_ax = (m_ax == NAXES - 1) ? 0 : m_ax + 1;
            m_ref = v;
         end
      end
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_stat(input int code, input string tag);
      for (int i = 0; i < 200 && int'(stat) != code; i++) @(negedge clk);
      chk(tag, int'(stat), code);
   endtask

   task automatic press(input logic c, input logic [NAXES-1:0] inc, input logic [NAXES-1:0] dec);
      btn_c = c; btn_inc = inc; btn_dec = dec;
      tick(4);
      btn_c = 1'b0; btn_inc = '0; btn_dec = '0;
      tick(4);
   endtask

   task automatic strobe(input int v);
      v_in = VW'(v); v_valid = 1'b1;
      @(negedge clk);
      v_valid = 1'b0;
      if (v > m_max) m_max = v;
   endtask

   task automatic push_state(input string tag);
      sb_push({tag, "_pos0"}, m_pos[0]);
      sb_push({tag, "_pos1"}, m_pos[1]);
      sb_push({tag, "_dir"},  m_dirv());
   endtask

   task automatic pop_state();
      sb_pop(p0());
      sb_pop(p1());
      sb_pop(int'(dir));
   endtask

   task automatic feed(input int v, input bit is_init, input string tag);
      wait_stat(is_init ? 1 : 4, {tag, "_ready"});
      strobe(v);
      if (is_init) begin m_ref = v; m_fail = 0; end
      else m_decide(v);
      m_move();
      push_state(tag);
      wait_stat(3, {tag, "_settle"});
      pop_state();
   endtask

   task automatic count_high(input int ax, output int n);
      n = 0;
      for (int i = 0; i < PERIOD; i++) begin
         @(negedge clk);
         if (servo[ax]) n++;
      end
   endtask

   initial begin
      int hi;
      int found;
      logic prev;

      // 1: reset and PWM with default positions
      m_reset();
      tick(3);
      rst_n = 1'b1;
      tick(PERIOD);
      push_state("rst");
      sb_push("rst_stat", 0);
      sb_push("rst_maxv", 0);
      pop_state();
      sb_pop(int'(stat));
      sb_pop(int'(max_v));
      sb_push("rst_pwm0", PMIN + m_pos[0] * PK);
      sb_push("rst_pwm1", PMIN + m_pos[1] * PK);
      count_high(0, hi); sb_pop(hi);
      count_high(1, hi); sb_pop(hi);

      // 2: manual jog and saturation
      for (int k = 0; k < 5; k++) begin press(1'b0, 2'b01, 2'b00); m_jog(0, 1); end
      sb_push("man_inc5", m_pos[0]); sb_pop(p0());
      btn_dec = 2'b10; tick(100); btn_dec = '0; tick(4); m_jog(1, 0);
      sb_push("man_hold", m_pos[1]); sb_pop(p1());
      for (int k = 0; k < 40; k++) begin press(1'b0, 2'b00, 2'b10); m_jog(1, 0); end
      sb_push("man_sat0", m_pos[1]); sb_pop(p1());
      press(1'b0, 2'b01, 2'b01);
      push_state("man_both");
      sb_push("man_stat", 0);
      pop_state();
      sb_pop(int'(stat));

      // reset asserted mid-frame while the pulse is high
      found = 0;
      for (int i = 0; i < 2 * PERIOD && !found; i++) begin
         @(negedge clk);
         if (servo[0]) found = 1;
      end
      chk("mid_rst_find_high", found, 1);
      rst_n = 1'b0;
      #1;
      m_reset();
      sb_push("mid_rst_servo", 0);
      push_state("mid_rst");
      sb_push("mid_rst_stat", 0);
      sb_pop(int'(servo));
      pop_state();
      sb_pop(int'(stat));
      @(negedge clk);
      rst_n = 1'b1;
      tick(2);

      // 3: auto climb, with a strobe during SETTLE that must be ignored
      press(1'b1, 2'b00, 2'b00);
      feed(500, 1'b1, "init500");
      strobe(100);
      m_max = (m_max > 100) ? m_max : m_max;
      chk("settle_ignore_stat", int'(stat), 3);
      feed(520, 1'b0, "climb520");
      feed(540, 1'b0, "climb540");

      // 4: reversal then hand-over to axis 1
      feed(520, 1'b0, "rev520");
      feed(525, 1'b0, "hand525");
      feed(530, 1'b0, "ax1_530");
      sb_push("auto_maxv", m_max); sb_pop(int'(max_v));

      // 5: mode switch while settling (feed returns on the first SETTLE cycle)
      btn_c = 1'b1;
      tick(2);
      chk("sw_still_settle", int'(stat), 3);
      tick(1);
      chk("sw_manual", int'(stat), 0);
      btn_c = 1'b0;
      tick(4);
      push_state("sw_hold");
      pop_state();
      strobe(3000);
      tick(10);
      strobe(2000);
      tick(10);
      sb_push("sw_maxv", m_max);
      sb_push("sw_stat", 0);
      push_state("sw_after_v");
      sb_pop(int'(max_v));
      sb_pop(int'(stat));
      pop_state();

      // 6: POS change mid-pulse only affects the following frame
      found = 0;
      prev = servo[0];
      for (int i = 0; i < 2 * PERIOD && !found; i++) begin
         @(negedge clk);
         if (servo[0] && !prev) found = 1;
         prev = servo[0];
      end
      chk("pwm_rise_found", found, 1);
      sb_push("pwm_cur_frame", PMIN + m_pos[0] * PK);
      m_jog(0, 1);
      sb_push("pwm_next_frame", PMIN + m_pos[0] * PK);
      hi = int'(servo[0]);
      for (int i = 1; i < PERIOD; i++) begin
         if (i == 20) btn_inc = 2'b01;
         if (i == 26) btn_inc = 2'b00;
         @(negedge clk);
         if (servo[0]) hi++;
      end
      sb_pop(hi);
      count_high(0, hi);
      sb_pop(hi);
      sb_push("pwm_pos0", m_pos[0]); sb_pop(p0());

      chk("sb_drained", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
